// File: rtl/ddr_mon_pkg.sv
// Shared types and helpers for the DDR command/address monitor: command
// encodings, the record carried through the output FIFO, and address rebuild.
package ddr_mon_pkg;

    localparam int unsigned REC_ADDR_W = 32;

    // {cke, cs_n, ras_n, cas_n, we_n}; IGNORE stands for cke = 0 or cs_n = 1
    typedef enum logic [4:0] {
        CMD_IGNORE = 5'b00000,
        CMD_MRS    = 5'b10000,
        CMD_REF    = 5'b10001,
        CMD_PRE    = 5'b10010,
        CMD_ACT    = 5'b10011,
        CMD_WRITE  = 5'b10100,
        CMD_READ   = 5'b10101,
        CMD_BST    = 5'b10110,
        CMD_NOP    = 5'b10111
    } ddr_cmd_e;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic                  is_wr;
        logic                  err;
    } ddr_rec_t;

    function automatic ddr_cmd_e ddr_decode(input logic [4:0] pins);
        if (!pins[4] || pins[3]) begin
            return CMD_IGNORE;
        end
        return ddr_cmd_e'(pins);
    endfunction

    // {row, bank, col[col_w-1:2], 3'b000}; callers truncate to their bus width
    function automatic logic [63:0] ddr_bus_addr(
        input logic [31:0] row,
        input logic [7:0]  bank,
        input logic [15:0] col,
        input int unsigned bank_w,
        input int unsigned col_w
    );
        logic [63:0] w_row;
        logic [63:0] w_bank;
        logic [63:0] w_col;
        w_row  = {32'b0, row}  << (bank_w + col_w + 1);
        w_bank = {56'b0, bank} << (col_w + 1);
        w_col  = ({48'b0, col} >> 2) << 3;
        return w_row | w_bank | w_col;
    endfunction

endpackage

// File: rtl/ddr_rec_fifo.sv
// Synchronous FIFO of monitor records; head entry is presented combinationally
// and storage is cleared on reset so idle outputs read as zero.
module ddr_rec_fifo
    import ddr_mon_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         rec_t = ddr_rec_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  rec_t i_data,
    input  logic i_pop,
    output rec_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    rec_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ddr_cmd_addr_tracker.sv
// Passive DDR command/address monitor: tracks open rows per bank, rebuilds the
// bus address of each READ/WRITE into a record FIFO, and keeps traffic stats.
module ddr_cmd_addr_tracker
    import ddr_mon_pkg::*;
#(
    parameter int unsigned DDR_ADDR_WIDTH = 16,
    parameter int unsigned DDR_BANK_WIDTH = 3,
    parameter int unsigned DDR_ROW_WIDTH  = 16,
    parameter int unsigned DDR_COL_WIDTH  = 10,
    parameter int unsigned BUS_ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cke,
    input  logic                      cs_n,
    input  logic                      ras_n,
    input  logic                      cas_n,
    input  logic                      we_n,
    input  logic [DDR_BANK_WIDTH-1:0] bank,
    input  logic [DDR_ADDR_WIDTH-1:0] ddr_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BUS_ADDR_WIDTH-1:0] out_addr,
    output logic                      out_is_wr,
    output logic                      out_err,
    input  logic                      stat_clr,
    output logic [31:0]               rd_cnt,
    output logic [31:0]               wr_cnt,
    output logic [31:0]               act_cnt,
    output logic [15:0]               drop_cnt,
    output logic                      err_sticky,
    output logic                      ovf_sticky
);

    localparam int unsigned NBANK = 2**DDR_BANK_WIDTH;

    typedef struct packed {
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic                      is_wr;
        logic                      err;
    } trk_rec_t;

    ddr_cmd_e                  r_cmd;
    logic [DDR_BANK_WIDTH-1:0] r_bank;
    logic [DDR_ADDR_WIDTH-1:0] r_addr;

    logic [NBANK-1:0]          r_open;
    logic [DDR_ROW_WIDTH-1:0]  r_row [NBANK];

    logic [31:0]               r_rd_cnt;
    logic [31:0]               r_wr_cnt;
    logic [31:0]               r_act_cnt;
    logic [15:0]               r_drop_cnt;
    logic                      r_err_sticky;
    logic                      r_ovf_sticky;

    logic                      w_bank_open;
    logic                      w_is_rw;
    logic [DDR_ROW_WIDTH-1:0]  w_row;
    logic [DDR_COL_WIDTH-1:0]  w_col;
    logic                      w_err_evt;
    logic                      w_rd_evt;
    logic                      w_wr_evt;
    logic                      w_act_evt;
    trk_rec_t                  w_rec;
    trk_rec_t                  w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;

    // Stage 1: capture the pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd  <= CMD_IGNORE;
            r_bank <= '0;
            r_addr <= '0;
        end else begin
            r_cmd  <= ddr_decode({cke, cs_n, ras_n, cas_n, we_n});
            r_bank <= bank;
            r_addr <= ddr_addr;
        end
    end

    // Stage 2 sees the table exactly as the previous command left it
    always_comb begin
        w_bank_open = r_open[r_bank];
        w_is_rw     = (r_cmd == CMD_READ) || (r_cmd == CMD_WRITE);
        w_row       = w_bank_open ? r_row[r_bank] : '0;
        w_col       = r_addr[DDR_COL_WIDTH-1:0];
        w_rd_evt    = (r_cmd == CMD_READ);
        w_wr_evt    = (r_cmd == CMD_WRITE);
        w_act_evt   = (r_cmd == CMD_ACT);
        w_err_evt   = (w_act_evt && w_bank_open)
                    || ((r_cmd == CMD_REF) && (|r_open))
                    || (w_is_rw && !w_bank_open);
    end

    always_comb begin
        w_rec       = '0;
        w_rec.addr  = BUS_ADDR_WIDTH'(ddr_bus_addr(32'(w_row), 8'(r_bank), 16'(w_col),
                                                   DDR_BANK_WIDTH, DDR_COL_WIDTH));
        w_rec.is_wr = w_wr_evt;
        w_rec.err   = !w_bank_open;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open <= '0;
            for (int unsigned i = 0; i < NBANK; i++) begin
                r_row[i] <= '0;
            end
        end else begin
            case (r_cmd)
                CMD_ACT: begin
                    r_open[r_bank] <= 1'b1;
                    r_row[r_bank]  <= r_addr[DDR_ROW_WIDTH-1:0];
                end
                CMD_PRE: begin
                    if (r_addr[10]) begin
                        r_open <= '0;
                    end else begin
                        r_open[r_bank] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign w_pop  = !w_empty && out_ready;
    assign w_push = w_is_rw && (!w_full || w_pop);
    assign w_drop = w_is_rw && w_full && !w_pop;

    ddr_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (trk_rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_act_cnt    <= '0;
            r_drop_cnt   <= '0;
            r_err_sticky <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (w_rd_evt && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_evt && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (w_act_evt && (r_act_cnt != '1)) begin
                r_act_cnt <= r_act_cnt + 32'd1;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_err_sticky <= r_err_sticky | w_err_evt;
            r_ovf_sticky <= r_ovf_sticky | w_drop;
        end
    end

    assign out_valid  = !w_empty;
    assign out_addr   = w_head.addr;
    assign out_is_wr  = w_head.is_wr;
    assign out_err    = w_head.err;
    assign rd_cnt     = r_rd_cnt;
    assign wr_cnt     = r_wr_cnt;
    assign act_cnt    = r_act_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign err_sticky = r_err_sticky;
    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_ddr_cmd_addr_tracker.sv
// Self-checking bench for ddr_cmd_addr_tracker: directed scenarios plus random
// traffic, all compared against a queue/array reference model.
module tb_ddr_cmd_addr_tracker;

    localparam int BW    = 3;
    localparam int CW    = 10;
    localparam int DEPTH = 8;

    localparam logic [4:0] P_NOP = 5'b10111;
    localparam logic [4:0] P_ACT = 5'b10011;
    localparam logic [4:0] P_RD  = 5'b10101;
    localparam logic [4:0] P_WR  = 5'b10100;
    localparam logic [4:0] P_PRE = 5'b10010;
    localparam logic [4:0] P_REF = 5'b10001;
    localparam logic [4:0] P_MRS = 5'b10000;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        err;
    } rec_s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  bank = '0;
    logic [15:0] ddr_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic        out_is_wr;
    logic        out_err;
    logic        stat_clr = 1'b0;
    logic [31:0] rd_cnt, wr_cnt, act_cnt;
    logic [15:0] drop_cnt;
    logic        err_sticky, ovf_sticky;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_open [8];
    logic [15:0] m_row  [8];
    rec_s        exp_q[$];
    rec_s        exp_pop_q[$];
    rec_s        obs_q[$];
    logic [4:0]  m_pins;
    logic [2:0]  m_bank;
    logic [15:0] m_addr;
    longint      m_rd, m_wr, m_act, m_drop;
    bit          m_err, m_ovf;

    always #5 clk = ~clk;

    ddr_cmd_addr_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .cke        (cke),
        .cs_n       (cs_n),
        .ras_n      (ras_n),
        .cas_n      (cas_n),
        .we_n       (we_n),
        .bank       (bank),
        .ddr_addr   (ddr_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_is_wr  (out_is_wr),
        .out_err    (out_err),
        .stat_clr   (stat_clr),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .act_cnt    (act_cnt),
        .drop_cnt   (drop_cnt),
        .err_sticky (err_sticky),
        .ovf_sticky (ovf_sticky)
    );

    function automatic logic [31:0] exp_addr(input logic [15:0] row, input logic [2:0] b,
                                             input logic [15:0] col);
        longint a;
        a = longint'(row) * (64'd1 << (BW + CW + 1))
          + longint'(b) * (64'd1 << (CW + 1))
          + longint'(col % (1 << CW)) / 4 * 8;
        return a[31:0];
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // Applies one clock edge's worth of behaviour to the model
    task automatic model_edge(input bit rdy, input bit clr);
        bit     pop, have, err_ev, rd_ev, wr_ev, act_ev, drop_ev, any_open;
        int     sz;
        rec_s   r;
        logic [2:0] b;
        sz = exp_q.size();
        pop = (sz > 0) && rdy;
        have = 0; err_ev = 0; rd_ev = 0; wr_ev = 0; act_ev = 0; drop_ev = 0;
        b = m_bank;
        any_open = 0;
        foreach (m_open[i]) any_open |= m_open[i];
        if (m_pins[4] && !m_pins[3]) begin
            case (m_pins)
                P_ACT: begin
                    act_ev = 1;
                    if (m_open[b]) err_ev = 1;
                    m_open[b] = 1;
                    m_row[b] = m_addr;
                end
                P_PRE: begin
                    if (m_addr[10]) foreach (m_open[i]) m_open[i] = 0;
                    else m_open[b] = 0;
                end
                P_REF: if (any_open) err_ev = 1;
                P_RD, P_WR: begin
                    have = 1;
                    r.err = !m_open[b];
                    r.wr = (m_pins == P_WR);
                    r.addr = exp_addr(m_open[b] ? m_row[b] : 16'h0, b, m_addr);
                    if (r.err) err_ev = 1;
                    if (r.wr) wr_ev = 1; else rd_ev = 1;
                end
                default: ;
            endcase
        end
        if (pop) exp_pop_q.push_back(exp_q.pop_front());
        if (have) begin
            if (sz < DEPTH || pop) exp_q.push_back(r);
            else drop_ev = 1;
        end
        if (clr) begin
            m_rd = 0; m_wr = 0; m_act = 0; m_drop = 0; m_err = 0; m_ovf = 0;
        end else begin
            if (rd_ev)   m_rd   = sat(m_rd, 64'hFFFF_FFFF);
            if (wr_ev)   m_wr   = sat(m_wr, 64'hFFFF_FFFF);
            if (act_ev)  m_act  = sat(m_act, 64'hFFFF_FFFF);
            if (drop_ev) m_drop = sat(m_drop, 64'hFFFF);
            m_err |= err_ev;
            m_ovf |= drop_ev;
        end
    endtask

    // One clock: drive at negedge, record any handshake, advance model at posedge
    task automatic step(input logic [4:0] pins, input logic [2:0] b, input logic [15:0] a,
                        input bit rdy, input bit clr);
        {cke, cs_n, ras_n, cas_n, we_n} = pins;
        bank = b; ddr_addr = a; out_ready = rdy; stat_clr = clr;
        #1;
        if (out_valid && rdy) obs_q.push_back('{addr: out_addr, wr: out_is_wr, err: out_err});
        @(posedge clk);
        model_edge(rdy, clr);
        m_pins = pins; m_bank = b; m_addr = a;
        @(negedge clk);
    endtask

    task automatic do_reset();
        {cke, cs_n, ras_n, cas_n, we_n} = P_NOP;
        out_ready = 0; stat_clr = 0; rst = 1;
        @(posedge clk);
        foreach (m_open[i]) begin m_open[i] = 0; m_row[i] = '0; end
        exp_q.delete();
        m_pins = 5'b00000; m_bank = '0; m_addr = '0;
        m_rd = 0; m_wr = 0; m_act = 0; m_drop = 0; m_err = 0; m_ovf = 0;
        @(negedge clk);
        rst = 0;
        obs_q.delete();
        exp_pop_q.delete();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(P_NOP, 3'd0, 16'h0, rdy, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 9;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", out_addr); end
        if (out_is_wr !== 1'b0) begin errors++; $display("FAIL reset_is_wr got %b want 0", out_is_wr); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", out_err); end
        if (rd_cnt !== 32'h0) begin errors++; $display("FAIL reset_rd_cnt got %0d want 0", rd_cnt); end
        if (wr_cnt !== 32'h0) begin errors++; $display("FAIL reset_wr_cnt got %0d want 0", wr_cnt); end
        if (act_cnt !== 32'h0) begin errors++; $display("FAIL reset_act_cnt got %0d want 0", act_cnt); end
        if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        if ({err_sticky, ovf_sticky} !== 2'b00) begin
            errors++; $display("FAIL reset_sticky got %b want 00", {err_sticky, ovf_sticky});
        end
    endtask

    task automatic test_act_write();
        do_reset();
        step(P_ACT, 3'd2, 16'h1234, 1, 0);
        step(P_WR, 3'd2, 16'h03FC, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL aw_early_valid got %b want 0", out_valid); end
        step(P_NOP, 3'd0, 16'h0, 0, 0);
        checks += 6;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL aw_valid got %b want 1", out_valid); end
        // {row 0x1234, bank 2, col[9:2] 0xFF, 3'b000}
        if (out_addr !== 32'h048D_17F8) begin errors++; $display("FAIL aw_addr got %h want 048d17f8", out_addr); end
        if (out_is_wr !== 1'b1) begin errors++; $display("FAIL aw_is_wr got %b want 1", out_is_wr); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL aw_err got %b want 0", out_err); end
        if (wr_cnt !== 32'd1) begin errors++; $display("FAIL aw_wr_cnt got %0d want 1", wr_cnt); end
        if (act_cnt !== 32'd1) begin errors++; $display("FAIL aw_act_cnt got %0d want 1", act_cnt); end
        step(P_NOP, 3'd0, 16'h0, 1, 0);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL aw_popped got %b want 0", out_valid); end
        if (obs_q.size() != 1 || exp_pop_q.size() != 1 || obs_q[0] != exp_pop_q[0]) begin
            errors++; $display("FAIL aw_record got %0d recs want %0d", obs_q.size(), exp_pop_q.size());
        end
    endtask

    task automatic test_closed_read();
        do_reset();
        step(P_RD, 3'd5, 16'h0010, 0, 0);
        idle(2, 0);
        checks += 5;
        if (out_addr !== exp_addr(16'h0, 3'd5, 16'h0010)) begin
            errors++; $display("FAIL cr_addr got %h want %h", out_addr, exp_addr(16'h0, 3'd5, 16'h0010));
        end
        if (out_err !== 1'b1) begin errors++; $display("FAIL cr_err got %b want 1", out_err); end
        if (out_is_wr !== 1'b0) begin errors++; $display("FAIL cr_is_wr got %b want 0", out_is_wr); end
        if (err_sticky !== 1'b1) begin errors++; $display("FAIL cr_sticky got %b want 1", err_sticky); end
        if (rd_cnt !== 32'd1) begin errors++; $display("FAIL cr_rd_cnt got %0d want 1", rd_cnt); end
    endtask

    task automatic test_precharge();
        do_reset();
        step(P_ACT, 3'd0, 16'h00AA, 1, 0);
        step(P_ACT, 3'd1, 16'h00BB, 1, 0);
        step(P_PRE, 3'd0, 16'h0400, 1, 0);
        step(P_RD,  3'd1, 16'h0020, 1, 0);
        step(P_ACT, 3'd0, 16'h00CC, 1, 0);
        step(P_ACT, 3'd1, 16'h00DD, 1, 0);
        step(P_PRE, 3'd0, 16'h0000, 1, 0);
        step(P_RD,  3'd1, 16'h0040, 1, 0);
        step(P_RD,  3'd0, 16'h0040, 1, 0);
        idle(4, 1);
        checks += 4;
        if (obs_q.size() != 3 || exp_pop_q.size() != 3) begin
            errors++; $display("FAIL pre_count got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (obs_q[i] != exp_pop_q[i]) begin
                    errors++; $display("FAIL pre_rec%0d got %h/%b want %h/%b", i, obs_q[i].addr,
                                       obs_q[i].err, exp_pop_q[i].addr, exp_pop_q[i].err);
                end
            end
            if ({obs_q[0].err, obs_q[1].err, obs_q[2].err} !== 3'b101) begin
                errors++; $display("FAIL pre_errs got %b want 101",
                                   {obs_q[0].err, obs_q[1].err, obs_q[2].err});
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] cols [10];
        do_reset();
        step(P_ACT, 3'd3, 16'h5A5A, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cols[i] = 16'($urandom_range(0, 1023));
            step(P_RD, 3'd3, cols[i], 0, 0);
        end
        idle(2, 0);
        checks += 4;
        if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_sticky); end
        if (rd_cnt !== 32'd10) begin errors++; $display("FAIL ovf_rd_cnt got %0d want 10", rd_cnt); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", out_valid); end
        idle(10, 1);
        checks++;
        if (obs_q.size() != 8) begin
            errors++; $display("FAIL ovf_pops got %0d want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[i].addr !== exp_addr(16'h5A5A, 3'd3, cols[i]) || obs_q[i].err !== 1'b0) begin
                    errors++; $display("FAIL ovf_order%0d got %h want %h", i, obs_q[i].addr,
                                       exp_addr(16'h5A5A, 3'd3, cols[i]));
                end
            end
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 9; i++) step(P_RD, 3'(i), 16'(i * 4), 0, 0);
        step(P_NOP, 3'd0, 16'h0, 1, 0);
        step(P_NOP, 3'd0, 16'h0, 0, 0);
        checks += 3;
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL fpp_drop got %0d want 0", drop_cnt); end
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", ovf_sticky); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fpp_valid got %b want 1", out_valid); end
        idle(10, 1);
        checks++;
        if (obs_q.size() != 9 || exp_pop_q.size() != 9) begin
            errors++; $display("FAIL fpp_pops got %0d want 9", obs_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (obs_q[i] != exp_pop_q[i]) begin
                    errors++; $display("FAIL fpp_rec%0d got %h want %h", i, obs_q[i].addr, exp_pop_q[i].addr);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        step(P_ACT, 3'd4, 16'h0777, 0, 0);
        for (int i = 0; i < 3; i++) step(P_RD, 3'd4, 16'(i * 8), 0, 0);
        step(P_WR, 3'd4, 16'h0100, 0, 0);
        do_reset();
        idle(3, 1);
        checks += 4;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rmo_leak got %0d want 0", obs_q.size()); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmo_valid got %b want 0", out_valid); end
        if ({rd_cnt, wr_cnt, act_cnt} !== 96'h0) begin
            errors++; $display("FAIL rmo_cnt got %0d/%0d/%0d want 0", rd_cnt, wr_cnt, act_cnt);
        end
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL rmo_sticky got %b want 0", err_sticky); end
        step(P_RD, 3'd4, 16'h0008, 0, 0);
        idle(2, 0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmo_rd_valid got %b want 1", out_valid); end
        if (out_err !== 1'b1) begin errors++; $display("FAIL rmo_rd_err got %b want 1", out_err); end
    endtask

    task automatic test_stat_clr();
        do_reset();
        step(P_ACT, 3'd6, 16'h0F0F, 0, 0);
        step(P_ACT, 3'd6, 16'h0F0F, 0, 0);
        step(P_RD,  3'd6, 16'h0030, 0, 0);
        step(P_NOP, 3'd0, 16'h0, 0, 1);
        idle(1, 0);
        checks += 4;
        if ({rd_cnt, act_cnt} !== 64'h0) begin
            errors++; $display("FAIL clr_cnt got %0d/%0d want 0/0", rd_cnt, act_cnt);
        end
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b want 0", err_sticky); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_fifo got %b want 1", out_valid); end
        if (out_addr !== exp_addr(16'h0F0F, 3'd6, 16'h0030) || out_err !== 1'b0) begin
            errors++; $display("FAIL clr_table got %h/%b want %h/0", out_addr, out_err,
                               exp_addr(16'h0F0F, 3'd6, 16'h0030));
        end
    endtask

    task automatic test_random();
        logic [4:0] p;
        int         sel;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2, 3: p = P_ACT;
                4, 5, 6:    p = P_RD;
                7, 8, 9:    p = P_WR;
                10, 11:     p = P_PRE;
                12:         p = P_REF;
                13:         p = P_MRS;
                14:         p = P_NOP;
                default:    p = ($urandom_range(0, 1) != 0) ? (P_RD & 5'b01111) : (P_WR | 5'b01000);
            endcase
            step(p, 3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) == 0));
        end
        idle(12, 1);
        checks += 8;
        if (obs_q.size() != exp_pop_q.size()) begin
            errors++; $display("FAIL rnd_pops got %0d want %0d", obs_q.size(), exp_pop_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] != exp_pop_q[i]) begin
                    errors++; $display("FAIL rnd_rec%0d got %h/%b/%b want %h/%b/%b", i, obs_q[i].addr,
                                       obs_q[i].wr, obs_q[i].err, exp_pop_q[i].addr,
                                       exp_pop_q[i].wr, exp_pop_q[i].err);
                end
            end
        end
        if (rd_cnt !== 32'(m_rd)) begin errors++; $display("FAIL rnd_rd_cnt got %0d want %0d", rd_cnt, m_rd); end
        if (wr_cnt !== 32'(m_wr)) begin errors++; $display("FAIL rnd_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
        if (act_cnt !== 32'(m_act)) begin errors++; $display("FAIL rnd_act_cnt got %0d want %0d", act_cnt, m_act); end
        if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop got %0d want %0d", drop_cnt, m_drop); end
        if (err_sticky !== m_err) begin errors++; $display("FAIL rnd_err got %b want %b", err_sticky, m_err); end
        if (ovf_sticky !== m_ovf) begin errors++; $display("FAIL rnd_ovf got %b want %b", ovf_sticky, m_ovf); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_valid got %b want 0", out_valid); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_act_write();
        test_closed_read();
        test_precharge();
        test_overflow();
        test_full_pushpop();
        test_reset_midop();
        test_stat_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
